// File: rtl/full_logic.sv
// Write-domain full-flag generator for the asynchronous FIFO: synchronises the Gray read pointer into
// clk_w and registers FIFO_full, write_adr_gray and wr_count. Define FULL_LOGIC_ALMOST_FULL_EN for almost_full.
module full_logic #(
   parameter int depth             = 8,
   parameter int adr_width         = $clog2(depth),
   parameter int sync_stages       = 2,
   parameter int almost_full_level = depth - 2
) (
   input  logic                 clk_w,
   input  logic                 reset,
   input  logic                 write,
   input  logic [adr_width:0]   write_adr,
   input  logic [adr_width:0]   read_adr_gray,
   output logic [adr_width:0]   write_adr_gray,
   output logic                 FIFO_full,
`ifdef FULL_LOGIC_ALMOST_FULL_EN
   output logic [adr_width:0]   wr_count,
   output logic                 almost_full
`else
   output logic [adr_width:0]   wr_count
`endif
);

   typedef logic [adr_width:0] ptr_t;

   if (depth < 4 || (depth & (depth - 1)) != 0 || sync_stages < 2 || sync_stages > 4 ||
       almost_full_level < 1 || almost_full_level > depth - 1) begin : g_bad_params
      $error("full_logic: illegal parameter value");
   end

   function automatic ptr_t gray_to_bin(input ptr_t g);
      ptr_t b;
      b = g;
      for (int i = adr_width - 1; i >= 0; i--) begin
         b[i] = b[i + 1] ^ g[i];
      end
      return b;
   endfunction

   ptr_t sync_q [sync_stages];
   ptr_t sync_d [sync_stages];
   ptr_t write_adr_gray_q, write_adr_gray_d;
   ptr_t wr_count_q, wr_count_d;
   logic full_q, full_d;

   logic wr_eff;
   ptr_t wnext, wgnext, rg_sync, rb_sync, occupancy;

   always_comb begin
      wr_eff    = write & ~full_q;
      wnext     = write_adr + {{adr_width{1'b0}}, wr_eff};
      wgnext    = wnext ^ (wnext >> 1);
      rg_sync   = sync_q[sync_stages - 1];
      rb_sync   = gray_to_bin(rg_sync);
      occupancy = wnext - rb_sync;

      // Pure shift register: nothing may sit between synchroniser stages.
      sync_d[0] = read_adr_gray;
      for (int i = 1; i < sync_stages; i++) begin
         sync_d[i] = sync_q[i - 1];
      end

      write_adr_gray_d = wgnext;
      // Full when the next write pointer is one lap ahead of the read pointer.
      full_d     = (wgnext == {~rg_sync[adr_width:adr_width-1], rg_sync[adr_width-2:0]});
      wr_count_d = occupancy;
   end

   always_ff @(posedge clk_w or negedge reset) begin
      if (!reset) begin
         // NOTE: the synchroniser array is cleared element by element; unlike RAM it must reset.
         for (int i = 0; i < sync_stages; i++) begin
            sync_q[i] <= '0;
         end
         write_adr_gray_q <= '0;
         wr_count_q       <= '0;
         full_q           <= 1'b0;
      end else begin
         // NOTE: non-blocking so every stage samples its predecessor's old value.
         sync_q           <= sync_d;
         write_adr_gray_q <= write_adr_gray_d;
         wr_count_q       <= wr_count_d;
         full_q           <= full_d;
      end
   end

   assign write_adr_gray = write_adr_gray_q;
   assign FIFO_full      = full_q;
   assign wr_count       = wr_count_q;

`ifdef FULL_LOGIC_ALMOST_FULL_EN
   localparam ptr_t af_level = ptr_t'(almost_full_level);

   logic almost_full_q, almost_full_d;

   always_comb begin
      almost_full_d = (occupancy >= af_level);
   end

   always_ff @(posedge clk_w or negedge reset) begin
      if (!reset) begin
         almost_full_q <= 1'b0;
      end else begin
         almost_full_q <= almost_full_d;
      end
   end

   assign almost_full = almost_full_q;
`endif

endmodule

// File: doc/full_logic.md
# full_logic

Write-domain full-flag generator for the asynchronous FIFO, clocked by `clk_w`. It sits directly downstream of the write-pointer stage and consumes that stage's `write` strobe and binary `write_adr`. It synchronises the read-domain Gray read pointer into `clk_w` and produces the registered `FIFO_full` flag that the write-pointer stage gates `wr_en` with. It also publishes the Gray-coded write pointer for the read domain and a write-side occupancy count.

## Interface
- `depth`, 8: FIFO entries; must be a power of two, ≥ 4.
- `adr_width`, `$clog2(depth)`: RAM address width; pointers are `adr_width+1` bits.
- `sync_stages`, 2: flops in the read-pointer synchroniser; legal range 2–4.
- `almost_full_level`, `depth-2`: occupancy threshold for `almost_full`; legal range 1…depth-1.

- `clk_w`  in  1  write-domain clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low reset; deassertion is synchronous to `clk_w` upstream.
- `write`  in  1  write strobe from the write-pointer stage (already gated by `FIFO_full`).
- `write_adr`  in  adr_width+1  binary write pointer from the write-pointer stage (registered there).
- `read_adr_gray`  in  adr_width+1  Gray read pointer from the read domain; asynchronous to `clk_w`.
- `write_adr_gray`  out  adr_width+1  registered Gray write pointer, sent to the read domain.
- `FIFO_full`  out  1  registered full flag.
- `wr_count`  out  adr_width+1  registered occupancy as seen from the write side, 0…depth.
- `almost_full`  out  1  registered; present only with `FULL_LOGIC_ALMOST_FULL_EN`.

## Operation
- **Effective write:** `wr_eff = write & ~FIFO_full`. A `write` that arrives while full is ignored here.
- **Next write pointer:** `wnext = write_adr + wr_eff`, computed modulo 2^(adr_width+1). This is the value `write_adr` takes after the current edge.
- **Gray write pointer:** `wgnext = wnext ^ (wnext >> 1)`. `write_adr_gray` is loaded with `wgnext` every edge, so it always equals the Gray code of the current `write_adr`.
- **Read-pointer synchroniser:** a `sync_stages`-deep shift register of `adr_width+1`-bit flops samples `read_adr_gray`. The last stage is `rg_sync`. No logic is allowed between the stages.
- **Read-pointer decode:** `rb_sync` is the binary decode of `rg_sync`, using an XOR prefix from the MSB downwards.
- **Full:** `FIFO_full` is loaded each edge with `wgnext == {~rg_sync[adr_width:adr_width-1], rg_sync[adr_width-2:0]}`.
- **Count:** `wr_count` is loaded each edge with `wnext - rb_sync`, computed modulo 2^(adr_width+1).
- **Arithmetic:** all pointer arithmetic is unsigned and at full `adr_width+1` width. Wrap-around of both pointers is natural rollover, with no special case.
- **Reset values (reset low):** `write_adr_gray` = 0, all synchroniser stages = 0, `FIFO_full` = 0, `wr_count` = 0, `almost_full` = 0.
- **Reset mid-operation:** outputs clear immediately and asynchronously. The flags stay 0 until the first edge after release; the pointers are consistent because the write-pointer stage resets to 0 in the same reset.

## Timing
- **`write_adr_gray`:** updated on the same edge that advances `write_adr`.
- **Assertion of `FIFO_full`:** the flag rises on the same edge as the write that fills the FIFO, so the write-pointer stage sees it combinationally in the next cycle and no overfill is possible.
- **Read-side changes:**
  - A new `read_adr_gray` is first captured at edge N.
  - It is visible in `FIFO_full`, `wr_count` and `almost_full` after edge N + `sync_stages`.
- **Deassertion of `FIFO_full`:** therefore lags the read by `sync_stages`+1 edges. This lag is pessimistic and safe.
- **Simultaneous write and read-pointer change:** both are reflected when the synchronised value arrives. Occupancy is computed from `wnext` and `rb_sync` as they stand at that edge.
- **Input stability:** `read_adr_gray` changes by at most one bit per read clock, which is guaranteed by the read domain. Metastability is therefore confined to a single bit.

## Configuration
- **`FULL_LOGIC_ALMOST_FULL_EN` defined:**
  - The `almost_full` port exists.
  - Each edge it is loaded with `(wnext - rb_sync) >= almost_full_level`.
- **Macro undefined:** the port and its logic are absent, and all other behaviour is identical.

## Test plan
All scenarios use `depth=8`, `sync_stages=2`, and the read pointer held at 0 unless stated otherwise.
- **Reset:** assert `reset` low mid-run with `wr_count=5` → all outputs read 0 immediately (before the next edge) and stay 0 until the first write after release.
- **Fill:** 8 consecutive writes from empty → after the 8th edge, `FIFO_full`=1, `wr_count`=8 and `write_adr_gray`=4'b1100. Before that, `FIFO_full`=0 and `wr_count` steps 1…7.
- **Ignored write:** `write`=1 while `FIFO_full`=1 → `wr_count` stays 8, `write_adr_gray` stays 4'b1100, and `FIFO_full` stays 1.
- **Read release:** with the FIFO full, change `read_adr_gray` to 4'b0001 (read pointer 1) just before edge N → `FIFO_full` falls and `wr_count`=7 after edge N+2, and not earlier.
- **Wrap:**
  - Step the read pointer to 8 (Gray 4'b1100).
  - Write 8 more entries so `write_adr` rolls from 15 to 0.
  - Required: `FIFO_full` rises on the write that makes `write_adr` = 0, with `write_adr_gray`=4'b0000 and `wr_count`=8.
- **Almost full (macro on):** with `almost_full_level`=6 → `almost_full` rises on the edge of the 6th write and falls 3 edges after a read brings occupancy back to 5.
